rf_pulse_tx: RTL

Transmit-side pulse modulator for the RF link, the counterpart of the rfin pulse receiver.
- Serialises one frame of {PREAMBLE, payload}, MSB first, at one bit per programmable bit period.
- For a 1 bit, emits a single high pulse of programmable width at mid-period; a 0 bit emits nothing.
- Sits beside the APB peripheral; register logic loads payload, period and pulse width, then pulses start.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_pulse_tx_if.sv | 19 +
 rtl/rf_bit_timer.sv | 56 +++++
 rtl/rf_pulse_tx.sv | 56 +++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and FSM state type for the rf_pulse_tx transmitter.
package rf_pkg;
    localparam int              PACKET_SIZE  = 24;
    localparam int              PREAMBLE_LEN = 8;
    localparam logic [7:0]      PREAMBLE     = 8'hFF;
    localparam int              N            = PREAMBLE_LEN + PACKET_SIZE;
    localparam int              CNT_W        = 20;
    localparam logic [15:0]     LFSR_SEED    = 16'hACE1;
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
endpackage

// File: rtl/rf_pulse_tx_if.sv
// rf_pulse_tx_if: frame request/status bundle between register logic and rf_pulse_tx.
interface rf_pulse_tx_if #(
    parameter int PACKET_SIZE = rf_pkg::PACKET_SIZE,
    parameter int CNT_W       = rf_pkg::CNT_W
);
    logic                   i_start;
    logic [PACKET_SIZE-1:0] i_data;
    logic [CNT_W-1:0]       i_period;
    logic [CNT_W-1:0]       i_high;
    logic                   o_ready;
    logic                   o_busy;
    logic                   o_rfout;
    logic                   o_done;
    logic [5:0]             o_bit_idx;
    modport master (output i_start, i_data, i_period, i_high,
                    input  o_ready, o_busy, o_rfout, o_done, o_bit_idx);
    modport slave  (input  i_start, i_data, i_period, i_high,
                    output o_ready, o_busy, o_rfout, o_done, o_bit_idx);
endinterface

// File: rtl/rf_bit_timer.sv
// rf_bit_timer: bit-period counter, pulse window and bit-end strobe.
// Define RF_JITTER_EN to dither the pulse position per bit from a 16-bit LFSR.
module rf_bit_timer import rf_pkg::*; #(
    parameter int CNT_W = rf_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] high_i,
    output logic             bit_end_o,
    output logic             win_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d, pe_q, pe_d, pos_q, pos_d, he_q, he_d, hmin, pj_d;
    // Window is evaluated on next-cycle values so the registered output lines up with cnt.
    always_comb begin
        hmin      = high_i == '0 ? CNT_W'(1) : high_i;
        pe_d      = load_i ? (period_i < CNT_W'(2) ? CNT_W'(2) : period_i) : pe_q;
        pos_d     = load_i ? pe_d >> 1 : pos_q;
        he_d      = load_i ? (hmin > pe_d - pos_d ? pe_d - pos_d : hmin) : he_q;
        bit_end_o = run_i && cnt_q == pe_q - CNT_W'(1);
        cnt_d     = (load_i || !run_i || bit_end_o) ? '0 : cnt_q + CNT_W'(1);
        win_o     = cnt_d >= pj_d && cnt_d - pj_d < he_d;
    end
`ifdef RF_JITTER_EN
    logic [15:0]    lfsr_q, lfsr_d;
    logic [CNT_W:0] sum;
    logic [CNT_W-1:0] lim;
    always_comb begin
        lfsr_d = bit_end_o ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
        sum    = {1'b0, pos_d} + (CNT_W+1)'(lfsr_d[2:0]);
        lim    = pe_d - he_d;
        pj_d   = sum < (CNT_W+1)'(4) ? '0 : CNT_W'(sum - (CNT_W+1)'(4));
        pj_d   = pj_d > lim ? lim : pj_d;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
`else
    always_comb pj_d = pos_d;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pe_q  <= '0;
            pos_q <= '0;
            he_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            pe_q  <= pe_d;
            pos_q <= pos_d;
            he_q  <= he_d;
        end
    end
endmodule

// File: rtl/rf_pulse_tx.sv
// rf_pulse_tx: serialises {PREAMBLE, payload} MSB first as one mid-period pulse per 1 bit.
// Optional RF_JITTER_EN macro enables per-bit pulse-position jitter in rf_bit_timer.
module rf_pulse_tx import rf_pkg::*; #(
    parameter int                      PACKET_SIZE  = rf_pkg::PACKET_SIZE,
    parameter int                      PREAMBLE_LEN = rf_pkg::PREAMBLE_LEN,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE     = rf_pkg::PREAMBLE,
    parameter int                      CNT_W        = rf_pkg::CNT_W
) (
    input  logic         i_PCLK,
    input  logic         i_PRESETn,
    rf_pulse_tx_if.slave bus
);
    localparam int NB = PREAMBLE_LEN + PACKET_SIZE;
    state_e          state_q, state_d;
    logic [NB-1:0]   sr_q, sr_d;
    logic [5:0]      idx_q, idx_d;
    logic            rf_q, rf_d, accept, bit_end, win;
    rf_bit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (i_PCLK),
        .rst_n    (i_PRESETn),
        .load_i   (accept),
        .run_i    (state_q == SEND),
        .period_i (bus.i_period),
        .high_i   (bus.i_high),
        .bit_end_o(bit_end),
        .win_o    (win)
    );
    // DONE accepts a new start too, so back-to-back frames have no gap bit.
    always_comb begin
        accept  = bus.i_start && state_q != SEND;
        state_d = accept ? SEND
                : state_q == SEND ? ((bit_end && idx_q == 6'(NB-1)) ? DONE : SEND)
                : IDLE;
        sr_d    = accept ? {PREAMBLE, bus.i_data} : bit_end ? sr_q << 1 : sr_q;
        idx_d   = accept ? '0 : bit_end ? idx_q + 6'd1 : idx_q;
        rf_d    = state_d == SEND && sr_d[NB-1] && win;
    end
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            rf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            rf_q    <= rf_d;
        end
    end
    assign bus.o_ready   = state_q != SEND;
    assign bus.o_busy    = state_q == SEND;
    assign bus.o_done    = state_q == DONE;
    assign bus.o_rfout   = rf_q;
    assign bus.o_bit_idx = idx_q;
endmodule
